rng_sample_ctrl: RTL and testbench



---
 rtl/rng_ctrl_pkg.sv | 6 +
 rtl/bit_sync.sv | 16 +
 rtl/rng_sample_ctrl.sv | 90 +++++++++
 tb/tb_rng_sample_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rng_ctrl_pkg.sv
// rng_ctrl_pkg: shared state encoding and widths for the entropy sampler
package rng_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, WARM, COLLECT, HOLD} state_t;
  localparam int BYTE_W = 8;
  localparam int SYNC_DEPTH = 2;
endpackage

// File: rtl/bit_sync.sv
// bit_sync: multi-flop synchronizer for an asynchronous single-bit input
module bit_sync
  import rng_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [SYNC_DEPTH-1:0] sr;
  // shift the input through the synchronizer chain
  always_ff @(posedge clk or posedge rst)
    if (rst) sr <= '0;
    else sr <= {sr[SYNC_DEPTH-2:0], d};
  assign q = sr[SYNC_DEPTH-1];
endmodule

// File: rtl/rng_sample_ctrl.sv
// rng_sample_ctrl: ring-oscillator sampler, byte packer and stuck-at monitor; RNG_VN_DEBIAS_EN enables von Neumann debiasing
module rng_sample_ctrl
  import rng_ctrl_pkg::*;
#(
  parameter int SAMPLE_DIV  = 16,
  parameter int WARMUP      = 64,
  parameter int STUCK_LIMIT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       ro_bit,
  output logic       ro_en,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       busy,
  output logic       stuck
);
  localparam int DW = $clog2(SAMPLE_DIV);
  localparam int WW = $clog2(WARMUP + 1);
  localparam int RW = $clog2(STUCK_LIMIT + 1);
  localparam int BW = $clog2(BYTE_W);
  state_t state, nxt;
  logic [DW-1:0] div;
  logic [WW-1:0] warm;
  logic [RW-1:0] run, run_nxt;
  logic [BW-1:0] bit_cnt;
  logic s, prev, tick, acc, bit_in, stuck_hit, done;
  bit_sync u_sync (.clk(clk), .rst(rst), .d(ro_bit), .q(s));
  // an enable drop in the tick cycle suppresses the sample entirely
  assign tick = state == COLLECT && enable && div == DW'(SAMPLE_DIV - 1);
  assign run_nxt = (run != '0 && s == prev) ? (run == RW'(STUCK_LIMIT) ? run : run + RW'(1)) : RW'(1);
  assign stuck_hit = tick && run_nxt == RW'(STUCK_LIMIT);
`ifdef RNG_VN_DEBIAS_EN
  logic phase, first;
  assign acc = tick && phase && first != s;
  assign bit_in = first;
  // pair tracking restarts on every COLLECT entry
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      phase <= 1'b0;
      first <= 1'b0;
    end else if (state != COLLECT) phase <= 1'b0;
    else if (tick) begin
      phase <= ~phase;
      first <= s;
    end
`else
  assign acc = tick;
  assign bit_in = s;
`endif
  assign done = acc && bit_cnt == BW'(BYTE_W - 1);
  assign byte_valid = state == HOLD;
  assign busy = state != IDLE;
  // next state; a stuck source always wins over a completed byte
  always_comb
    case (state)
      IDLE:    nxt = enable && !stuck ? WARM : IDLE;
      WARM:    nxt = !enable ? IDLE : warm == WW'(WARMUP - 1) ? COLLECT : WARM;
      COLLECT: nxt = !enable || stuck || stuck_hit ? IDLE : done ? HOLD : COLLECT;
      default: nxt = byte_ready ? (enable ? COLLECT : IDLE) : HOLD;
    endcase
  // state, counters, health test and byte assembly
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ro_en <= 1'b0;
      warm <= '0;
      div <= '0;
      run <= '0;
      prev <= 1'b0;
      stuck <= 1'b0;
      bit_cnt <= '0;
      byte_data <= '0;
    end else begin
      state <= nxt;
      ro_en <= nxt == WARM || nxt == COLLECT;
      warm <= state == WARM ? warm + WW'(1) : '0;
      div <= state == COLLECT && div != DW'(SAMPLE_DIV - 1) ? div + DW'(1) : '0;
      if (state == IDLE && nxt == WARM) run <= '0;
      else if (tick) begin
        run <= run_nxt;
        prev <= s;
      end
      if (stuck_hit) stuck <= 1'b1;
      bit_cnt <= nxt != COLLECT ? '0 : acc ? bit_cnt + BW'(1) : bit_cnt;
      if (acc && nxt != IDLE) byte_data <= {byte_data[BYTE_W-2:0], bit_in};
    end
endmodule

// File: tb/tb_rng_sample_ctrl.sv
// tb_rng_sample_ctrl: scoreboard bench for the entropy sampler (either debias build)
module tb_rng_sample_ctrl;
  localparam int SAMPLE_DIV = 4;
  localparam int WARMUP = 8;
  localparam int STUCK_LIMIT = 32;
`ifdef RNG_VN_DEBIAS_EN
  localparam logic [31:0] SA = 32'h9A59,   SB = 32'hB4AD49, SC = 32'h6996, SD = 32'h5A5A;
  localparam logic [31:0] SP = 32'h2AA,    SE = 32'h5565,   SR = 32'h2A;
  localparam int NA = 16, NB = 24, NC = 16, ND = 16, NP = 10, NE = 16, NR = 6;
`else
  localparam logic [31:0] SA = 32'hA7, SB = 32'h5C, SC = 32'h3D, SD = 32'hC6;
  localparam logic [31:0] SP = 32'h1F, SE = 32'h0C, SR = 32'h7;
  localparam int NA = 8, NB = 8, NC = 8, ND = 8, NP = 5, NE = 8, NR = 3;
`endif
  logic clk = 0, rst = 1, enable = 0, ro_bit = 0, byte_ready = 1;
  logic ro_en, byte_valid, busy, stuck;
  logic [7:0] byte_data;
  logic [7:0] sb[$];
  int checks = 0, failures = 0;

  rng_sample_ctrl #(.SAMPLE_DIV(SAMPLE_DIV), .WARMUP(WARMUP), .STUCK_LIMIT(STUCK_LIMIT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .ro_bit(ro_bit), .ro_en(ro_en),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .busy(busy), .stuck(stuck)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // expected bytes from a raw sample sequence (sample i is v[n-1-i])
  function automatic void sb_model(input logic [31:0] v, input int n);
    logic [7:0] b = '0;
    int k = 0;
    for (int i = 0; i < n; i++) begin
`ifdef RNG_VN_DEBIAS_EN
      if (i % 2 == 1 && v[n-i] != v[n-1-i]) begin
        b = {b[6:0], v[n-i]};
        k++;
      end
`else
      b = {b[6:0], v[n-1-i]};
      k++;
`endif
      if (k == 8) begin
        sb.push_back(b);
        k = 0;
      end
    end
  endfunction

  // called #1 after the COLLECT entry edge; one raw sample per divider period
  task automatic collect(input logic [31:0] v, input int n, input bit push);
    if (push) sb_model(v, n);
    ro_bit = v[n-1];
    for (int i = 0; i < n; i++) begin
      repeat (SAMPLE_DIV) @(posedge clk);
      #1;
      if (i + 1 < n) ro_bit = v[n-2-i];
    end
  endtask

  // called #1 after an edge in IDLE; returns #1 after the COLLECT entry edge
  task automatic start();
    enable = 1;
    @(posedge clk);
    #1;
    check("warm_ro_en", ro_en, 1);
    repeat (WARMUP) @(posedge clk);
    #1;
  endtask

  task automatic finish_byte();
    enable = 0;
    @(posedge clk);
    #1;
    check("post_hs_valid", byte_valid, 0);
    check("post_hs_busy", busy, 0);
  endtask

  // handshake monitor pops the scoreboard
  always @(negedge clk)
    if (!rst && byte_valid && byte_ready) begin
      check("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) check("byte", byte_data, sb.pop_front());
    end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ro_en", ro_en, 0);
    check("rst_data", byte_data, 0);
    check("rst_valid", byte_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_stuck", stuck, 0);
    rst = 0;
    @(posedge clk);
    #1;
    start();
    collect(SA, NA, 1);
    check("a_valid", byte_valid, 1);
    finish_byte();
    start();
    collect(SB, NB, 1);
    finish_byte();
    byte_ready = 0;
    start();
    collect(SC, NC, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_valid", byte_valid, 1);
      check("bp_ro_en", ro_en, 0);
      check("bp_data", byte_data, sb[0]);
    end
    @(posedge clk);
    #1;
    byte_ready = 1;
    @(posedge clk);
    #1;
    check("hs_valid_drop", byte_valid, 0);
    check("hs_busy", busy, 1);
    collect(SD, ND, 1);
    finish_byte();
    start();
    collect(SP, NP, 0);
    enable = 0;
    @(posedge clk);
    #1;
    check("abort_busy", busy, 0);
    check("abort_ro_en", ro_en, 0);
    repeat (3) @(posedge clk);
    #1;
    start();
    collect(SE, NE, 1);
    finish_byte();
    start();
    collect(SR, NR, 0);
    #2 rst = 1;
    #1;
    check("arst_ro_en", ro_en, 0);
    check("arst_data", byte_data, 0);
    check("arst_valid", byte_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_stuck", stuck, 0);
    enable = 0;
    @(posedge clk);
    #1 rst = 0;
    repeat (10) @(posedge clk);
    #1;
    check("arst_idle", busy, 0);
    start();
`ifdef RNG_VN_DEBIAS_EN
    collect('1, 32, 0);
`else
    for (int i = 0; i < 4; i++) begin
      collect('1, 8, i < 3);
      if (i < 3) begin
        @(posedge clk);
        #1;
      end
    end
`endif
    check("stuck_set", stuck, 1);
    check("stuck_busy", busy, 0);
    check("stuck_valid", byte_valid, 0);
    check("stuck_ro_en", ro_en, 0);
    enable = 0;
    repeat (2) @(posedge clk);
    #1 enable = 1;
    repeat (5) @(posedge clk);
    #1;
    check("stuck_hold", stuck, 1);
    check("stuck_norestart", busy, 0);
    check("stuck_ro_off", ro_en, 0);
    enable = 0;
    rst = 1;
    #1;
    check("stuck_clr", stuck, 0);
    @(posedge clk);
    #1 rst = 0;
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
